// File: rtl/rcv_buffer.sv
// rtl/rcv_buffer.sv - bit-serial receive FIFO: byte writes from the UART, one bit out per clk_1200 rising edge
module rcv_buffer #(
    parameter int   DEPTH_BITS = 10240,
    parameter int   BYTE_W     = 8,
    parameter logic IDLE_BIT   = 1'b1
) (
    input  logic              rcvbuf_clk,
    input  logic              reset,
    input  logic              clk_1200,
    input  logic              newdata,
    input  logic [BYTE_W-1:0] rbr,
    output logic              databit
);

    localparam int DEPTH_BYTES = DEPTH_BITS / 8;
    localparam int WPW         = $clog2(DEPTH_BYTES);
    localparam int RPW         = $clog2(DEPTH_BITS);
    localparam int CW          = $clog2(DEPTH_BITS + 1);

    // A write is accepted only while a whole byte still fits.
    localparam logic [CW-1:0]  WR_LIMIT = CW'(DEPTH_BITS - 8);
    localparam logic [WPW-1:0] WR_LAST  = WPW'(DEPTH_BYTES - 1);
    localparam logic [RPW-1:0] RD_LAST  = RPW'(DEPTH_BITS - 1);

    // Synchroniser and edge-detector stages for the two sampled strobes.
    logic c_s1_q, c_s2_q, c_prev_q;
    logic n_s1_q, n_s2_q, n_prev_q;

    logic [WPW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [RPW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              databit_q, databit_d;
    logic [BYTE_W-1:0] mem_q [0:DEPTH_BYTES-1];

    logic              rd_tick, wr_tick;
    logic              wr_ok, rd_ok;
    logic [BYTE_W-1:0] rd_byte;

    assign rd_tick = c_s2_q & ~c_prev_q;
    assign wr_tick = n_s2_q & ~n_prev_q;

    // Full/empty decisions use the count from before this cycle.
    assign wr_ok   = wr_tick && (count_q <= WR_LIMIT);
    assign rd_ok   = rd_tick && (count_q != '0);

    // The read byte comes from the pre-edge memory, so a same-cycle write is not visible.
    assign rd_byte = mem_q[rd_ptr_q[RPW-1:3]];
    assign databit = databit_q;

    // Next-state for pointers, occupancy and the output bit.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        databit_d = databit_q;

        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == WR_LAST) ? '0 : wr_ptr_q + WPW'(1);
        end

        if (rd_tick) begin
            if (rd_ok) begin
                databit_d = rd_byte[rd_ptr_q[2:0]];
                rd_ptr_d  = (rd_ptr_q == RD_LAST) ? '0 : rd_ptr_q + RPW'(1);
            end else begin
                databit_d = IDLE_BIT;
            end
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(8);
            2'b01:   count_d = count_q - CW'(1);
            2'b11:   count_d = count_q + CW'(7);
            default: count_d = count_q;
        endcase
    end

    // Control state, synchronisers and output register; reset wins over both ticks.
    always_ff @(posedge rcvbuf_clk) begin
        if (reset) begin
            c_s1_q    <= 1'b0;
            c_s2_q    <= 1'b0;
            c_prev_q  <= 1'b0;
            n_s1_q    <= 1'b0;
            n_s2_q    <= 1'b0;
            n_prev_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            databit_q <= IDLE_BIT;
        end else begin
            c_s1_q    <= clk_1200;
            c_s2_q    <= c_s1_q;
            c_prev_q  <= c_s2_q;
            n_s1_q    <= newdata;
            n_s2_q    <= n_s1_q;
            n_prev_q  <= n_s2_q;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            databit_q <= databit_d;
        end
    end

    // Byte storage; contents survive reset.
    always_ff @(posedge rcvbuf_clk) begin
        if (!reset && wr_ok) begin
            mem_q[wr_ptr_q] <= rbr;
        end
    end

endmodule

// File: tb/tb_rcv_buffer.sv
// tb/tb_rcv_buffer.sv - randomized self-checking bench for rcv_buffer against a bit-queue model
module tb_rcv_buffer;

    localparam int DEPTH = 10240;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_1200 = 1'b0;
    logic       newdata = 1'b0;
    logic [7:0] rbr = 8'h00;
    logic       databit;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO of bits, LSB of each byte first.
    bit q[$];

    rcv_buffer dut (
        .rcvbuf_clk (clk),
        .reset      (reset),
        .clk_1200   (clk_1200),
        .newdata    (newdata),
        .rbr        (rbr),
        .databit    (databit)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic m_write(input logic [7:0] b);
        if (q.size() <= DEPTH - 8) begin
            for (int i = 0; i < 8; i++) q.push_back(b[i]);
        end
    endtask

    function automatic bit m_read();
        if (q.size() == 0) return 1'b1;
        return q.pop_front();
    endfunction

    task automatic wr_byte(input logic [7:0] b, input int hold);
        rbr = b;
        newdata = 1'b1;
        cyc(hold);
        newdata = 1'b0;
        cyc(2);
        m_write(b);
    endtask

    task automatic req_bit();
        clk_1200 = 1'b1;
        cyc(2);
        clk_1200 = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset();
        bit exp;
        reset = 1'b1;
        newdata = 1'b1;
        rbr = 8'hA5;
        cyc(3);
        total++;
        if (databit !== 1'b1) begin
            bad++;
            $display("FAIL reset_databit: got=%b want=1", databit);
        end
        reset = 1'b0;
        cyc(6);
        newdata = 1'b0;
        cyc(2);
        q.delete();
        m_write(8'hA5);
        for (int i = 0; i < 10; i++) begin
            req_bit();
            exp = m_read();
            total++;
            if (databit !== exp) begin
                bad++;
                $display("FAIL reset_held_write bit%0d: got=%b want=%b", i, databit, exp);
            end
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 6; i++) begin
            clk_1200 = 1'b1;
            cyc(8);
            clk_1200 = 1'b0;
            cyc(8);
            total++;
            if (databit !== 1'b1) begin
                bad++;
                $display("FAIL idle_no_data req%0d: got=%b want=1", i, databit);
            end
        end
    endtask

    task automatic test_single_byte();
        bit exp;
        wr_byte(8'hF0, 10);
        for (int i = 0; i < 9; i++) begin
            req_bit();
            exp = m_read();
            total++;
            if (databit !== exp) begin
                bad++;
                $display("FAIL single_F0 bit%0d: got=%b want=%b", i, databit, exp);
            end
        end
    endtask

    task automatic test_order();
        bit exp;
        wr_byte(8'hF0, 3);
        wr_byte(8'h55, 3);
        for (int i = 0; i < 17; i++) begin
            req_bit();
            exp = m_read();
            total++;
            if (databit !== exp) begin
                bad++;
                $display("FAIL order_F0_55 bit%0d: got=%b want=%b", i, databit, exp);
            end
        end
    endtask

    task automatic test_long_pulse();
        bit exp;
        wr_byte(8'h00, 200);
        for (int i = 0; i < 10; i++) begin
            req_bit();
            exp = m_read();
            total++;
            if (databit !== exp) begin
                bad++;
                $display("FAIL long_pulse bit%0d: got=%b want=%b", i, databit, exp);
            end
        end
    endtask

    task automatic test_full_wrap();
        bit exp;
        for (int i = 0; i < 1281; i++) wr_byte(8'(i), 2);
        for (int i = 0; i < DEPTH + 1; i++) begin
            req_bit();
            exp = m_read();
            total++;
            if (databit !== exp) begin
                bad++;
                $display("FAIL full_drain bit%0d: got=%b want=%b", i, databit, exp);
            end
        end
        wr_byte(8'h3C, 2);
        wr_byte(8'hC9, 2);
        wr_byte(8'h81, 2);
        for (int i = 0; i < 25; i++) begin
            req_bit();
            exp = m_read();
            total++;
            if (databit !== exp) begin
                bad++;
                $display("FAIL after_wrap bit%0d: got=%b want=%b", i, databit, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit         exp;
        logic [7:0] b;
        bit         was_full;
        int         op;
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 2);
            b  = 8'($urandom);
            if (op == 0) begin
                wr_byte(b, $urandom_range(2, 5));
            end else if (op == 1) begin
                req_bit();
                exp = m_read();
                total++;
                if (databit !== exp) begin
                    bad++;
                    $display("FAIL rand_read op%0d: got=%b want=%b", n, databit, exp);
                end
            end else begin
                rbr = b;
                newdata = 1'b1;
                clk_1200 = 1'b1;
                cyc(2);
                newdata = 1'b0;
                clk_1200 = 1'b0;
                cyc(2);
                was_full = (q.size() > DEPTH - 8);
                exp = m_read();
                if (!was_full) begin
                    for (int i = 0; i < 8; i++) q.push_back(b[i]);
                end
                total++;
                if (databit !== exp) begin
                    bad++;
                    $display("FAIL simultaneous op%0d: got=%b want=%b", n, databit, exp);
                end
            end
        end
        while (q.size() > 0) begin
            req_bit();
            exp = m_read();
            total++;
            if (databit !== exp) begin
                bad++;
                $display("FAIL rand_drain: got=%b want=%b", databit, exp);
            end
        end
    endtask

    task automatic test_reset_midstream();
        bit exp;
        for (int i = 0; i < 5; i++) wr_byte(8'h00, 2);
        for (int i = 0; i < 3; i++) begin
            req_bit();
            exp = m_read();
            total++;
            if (databit !== exp) begin
                bad++;
                $display("FAIL pre_reset bit%0d: got=%b want=%b", i, databit, exp);
            end
        end
        reset = 1'b1;
        cyc(1);
        total++;
        if (databit !== 1'b1) begin
            bad++;
            $display("FAIL midstream_reset_databit: got=%b want=1", databit);
        end
        reset = 1'b0;
        q.delete();
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            req_bit();
            exp = m_read();
            total++;
            if (databit !== exp) begin
                bad++;
                $display("FAIL post_reset bit%0d: got=%b want=%b", i, databit, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_byte();
        test_order();
        test_long_pulse();
        test_back_to_back();
        test_full_wrap();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
